// File: rtl/fic0_apb_timer_slave.sv
// APB3 completer on the FIC_0 fabric side: ID, scratch and a 32-bit down-counting timer
// with a level interrupt, plus a configurable PREADY stall to exercise the master's wait path.
module fic0_apb_timer_slave #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h5346_0001
) (
    input  logic        MCCC_CLK_BASE,
    input  logic        MSS_RESET_N_M2F,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        TIMER_IRQ
);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    // Handshake: a transfer completes on the edge where PSEL, PENABLE and PREADY are all high;
    // PRDATA and PSLVERR are meaningful only in that cycle and are forced to 0 otherwise.
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] scratch;
    logic [31:0] load;
    logic [31:0] count;
    logic [2:0]  ctrl;
    logic        pending;

    logic [5:0]  idx;
    logic        bad_addr;
    logic        ro_write;
    logic        complete;
    logic        wr_ok;
    logic        scratch_wr, ctrl_wr, load_wr, status_wr;
    logic        expire;
    logic [31:0] rd_mux;
    logic        unused_paddr;

    assign idx          = PADDR[7:2];
    assign unused_paddr = ^{PADDR[31:8], PADDR[1:0]};
    assign bad_addr     = idx > 6'd5;
    assign ro_write     = PWRITE && (idx == 6'd0 || idx == 6'd4);

    assign PREADY   = (state == ACCESS) && (wait_cnt == 4'd0);
    assign complete = PSEL && PENABLE && PREADY;
    assign wr_ok    = complete && PWRITE && !bad_addr && !ro_write;

    assign scratch_wr = wr_ok && idx == 6'd1;
    assign ctrl_wr    = wr_ok && idx == 6'd2;
    assign load_wr    = wr_ok && idx == 6'd3;
    assign status_wr  = wr_ok && idx == 6'd5;

    // A LOAD write takes priority over the timer reaching zero on the same edge.
    assign expire = ctrl[0] && (count == 32'd0) && !load_wr;

    always_comb begin
        rd_mux = 32'd0;
        case (idx)
            6'd0:    rd_mux = ID_VALUE;
            6'd1:    rd_mux = scratch;
            6'd2:    rd_mux = {29'd0, ctrl};
            6'd3:    rd_mux = load;
            6'd4:    rd_mux = count;
            6'd5:    rd_mux = {31'd0, pending};
            default: rd_mux = 32'd0;
        endcase
    end

    assign PRDATA    = (PREADY && !PWRITE) ? rd_mux : 32'd0;
    assign PSLVERR   = PREADY && (bad_addr || ro_write);
    assign TIMER_IRQ = pending && ctrl[2];

    always_ff @(posedge MCCC_CLK_BASE or negedge MSS_RESET_N_M2F) begin
        if (!MSS_RESET_N_M2F) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state    <= ACCESS;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                ACCESS: begin
                    // PSEL dropping before completion is an abort: no register side effect.
                    if (!PSEL || complete) begin
                        state <= IDLE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge MCCC_CLK_BASE or negedge MSS_RESET_N_M2F) begin
        if (!MSS_RESET_N_M2F) begin
            scratch <= 32'd0;
            load    <= 32'd0;
            count   <= 32'd0;
            ctrl    <= 3'd0;
            pending <= 1'b0;
        end else begin
            if (scratch_wr) scratch <= PWDATA;

            if (load_wr) begin
                load  <= PWDATA;
                count <= PWDATA;
            end else if (ctrl[0] && count != 32'd0) begin
                count <= count - 32'd1;
            end else if (expire && ctrl[1]) begin
                count <= load;
            end

            // Firmware's CTRL write beats the one-shot EN self-clear.
            if (ctrl_wr) begin
                ctrl <= PWDATA[2:0];
            end else if (expire && !ctrl[1]) begin
                ctrl[0] <= 1'b0;
            end

            // Hardware set beats a write-1-to-clear on the same edge.
            if (expire) begin
                pending <= 1'b1;
            end else if (status_wr && PWDATA[0]) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fic0_apb_timer_slave.sv
// Directed bench for fic0_apb_timer_slave: two instances (0 and 3 wait states) share the bus
// except PSEL; expected values are hand-computed and checked with immediate assertions.
module tb_fic0_apb_timer_slave;
    localparam logic [31:0] ID = 32'h5346_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic [31:0] pwdata = 32'd0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic        psel0 = 1'b0;
    logic        psel3 = 1'b0;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3, irq0, irq3;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fic0_apb_timer_slave #(.WAIT_STATES(0)) dut0 (
        .MCCC_CLK_BASE(clk), .MSS_RESET_N_M2F(rst_n), .PADDR(paddr), .PSEL(psel0),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata0),
        .PREADY(pready0), .PSLVERR(pslverr0), .TIMER_IRQ(irq0)
    );

    fic0_apb_timer_slave #(.WAIT_STATES(3)) dut3 (
        .MCCC_CLK_BASE(clk), .MSS_RESET_N_M2F(rst_n), .PADDR(paddr), .PSEL(psel3),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata3),
        .PREADY(pready3), .PSLVERR(pslverr3), .TIMER_IRQ(irq3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer; starts its setup phase immediately, returns 1ns after the completion edge.
    task automatic apb(input logic use3, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int waits);
        bit done;
        paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
        if (use3) psel3 = 1'b1; else psel0 = 1'b1;
        waits = 0; rdata = 32'd0; err = 1'b0; done = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (use3 ? pready3 : pready0) begin
                rdata = use3 ? prdata3 : prdata0;
                err   = use3 ? pslverr3 : pslverr0;
                done  = 1'b1;
            end else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        check("pready_timeout", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input string tag, input logic use3, input logic [31:0] addr,
                      input logic [31:0] data, input logic exp_err);
        logic [31:0] rd; logic er; int nw;
        apb(use3, addr, 1'b1, data, rd, er, nw);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, "_waits"}, nw, use3 ? 32'd3 : 32'd0);
        check({tag, "_prdata"}, rd, 32'd0);
    endtask

    task automatic rd(input string tag, input logic use3, input logic [31:0] addr,
                      input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] d; logic er; int nw;
        apb(use3, addr, 1'b0, 32'd0, d, er, nw);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, "_waits"}, nw, use3 ? 32'd3 : 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: 5 cycles low, outputs quiet throughout.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_pready", {31'd0, pready0}, 32'd0);
        check("rst_pslverr", {31'd0, pslverr0}, 32'd0);
        check("rst_prdata", prdata0, 32'd0);
        check("rst_irq", {31'd0, irq0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        rd("id0", 1'b0, 32'h00, ID, 1'b0);
        rd("scratch_rst", 1'b0, 32'h04, 32'd0, 1'b0);
        rd("ctrl_rst", 1'b0, 32'h08, 32'd0, 1'b0);
        rd("load_rst", 1'b0, 32'h0C, 32'd0, 1'b0);
        rd("count_rst", 1'b0, 32'h10, 32'd0, 1'b0);
        rd("status_rst", 1'b0, 32'h14, 32'd0, 1'b0);
        check("irq_after_rst", {31'd0, irq0}, 32'd0);
        rd("id3", 1'b1, 32'h00, ID, 1'b0);

        // Wait states: 3 PREADY-low cycles on dut3, none on dut0.
        wr("ws3_wr", 1'b1, 32'h04, 32'hDEAD_BEEF, 1'b0);
        rd("ws3_rd", 1'b1, 32'h04, 32'hDEAD_BEEF, 1'b0);
        wr("ws0_wr", 1'b0, 32'h04, 32'h1234_5678, 1'b0);
        rd("ws0_rd", 1'b0, 32'h04, 32'h1234_5678, 1'b0);
        rd("alias_hi", 1'b0, 32'hFFFF_FF04, 32'h1234_5678, 1'b0);

        // Error responses.
        rd("bad_0x18", 1'b0, 32'h18, 32'd0, 1'b1);
        rd("bad_0xfc", 1'b0, 32'hFC, 32'd0, 1'b1);
        wr("wr_count", 1'b0, 32'h10, 32'd5, 1'b1);
        rd("count_kept", 1'b0, 32'h10, 32'd0, 1'b0);
        wr("wr_id", 1'b0, 32'h00, 32'hFFFF_FFFF, 1'b1);
        rd("id_kept", 1'b0, 32'h00, ID, 1'b0);
        wr("bad_wr_0x18", 1'b0, 32'h18, 32'hFFFF_FFFF, 1'b1);

        // One-shot: COUNT 3,2,1,0 then PENDING/IRQ, EN self-clears.
        wr("os_load", 1'b0, 32'h0C, 32'd3, 1'b0);
        wr("os_ctrl", 1'b0, 32'h08, 32'd5, 1'b0);
        exp_q.push_back(32'd3); exp_q.push_back(32'd2);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check("os_count", dut0.count, exp_q.pop_front());
            check("os_irq_low", {31'd0, irq0}, 32'd0);
        end
        @(negedge clk);
        check("os_irq_set", {31'd0, irq0}, 32'd1);
        check("os_count_hold", dut0.count, 32'd0);
        rd("os_ctrl_rd", 1'b0, 32'h08, 32'd4, 1'b0);
        rd("os_count_rd", 1'b0, 32'h10, 32'd0, 1'b0);
        rd("os_status_rd", 1'b0, 32'h14, 32'd1, 1'b0);
        wr("os_w1c", 1'b0, 32'h14, 32'd1, 1'b0);
        @(negedge clk);
        check("os_irq_clr", {31'd0, irq0}, 32'd0);

        // Auto-reload: COUNT 2,1,0,2,... with PENDING set every third edge.
        wr("ar_load", 1'b0, 32'h0C, 32'd2, 1'b0);
        wr("ar_ctrl", 1'b0, 32'h08, 32'd7, 1'b0);
        exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check("ar_count", dut0.count, exp_q.pop_front());
            check("ar_irq_low", {31'd0, irq0}, 32'd0);
        end
        @(negedge clk);
        check("ar_reload", dut0.count, 32'd2);
        check("ar_irq_set", {31'd0, irq0}, 32'd1);
        @(negedge clk);
        check("ar_count1", dut0.count, 32'd1);
        // This W1C completes on the next set edge, so PENDING must stay 1.
        wr("ar_w1c_set_edge", 1'b0, 32'h14, 32'd1, 1'b0);
        @(negedge clk);
        check("ar_set_wins", {31'd0, irq0}, 32'd1);
        check("ar_reload2", dut0.count, 32'd2);
        // This W1C lands on a decrement edge and does clear.
        wr("ar_w1c_plain", 1'b0, 32'h14, 32'd1, 1'b0);
        @(negedge clk);
        check("ar_cleared", {31'd0, irq0}, 32'd0);
        check("ar_count0", dut0.count, 32'd0);
        @(negedge clk);
        check("ar_irq_again", {31'd0, irq0}, 32'd1);
        check("ar_reload3", dut0.count, 32'd2);
        wr("ar_stop", 1'b0, 32'h08, 32'd4, 1'b0);
        check("ar_irq_held", {31'd0, irq0}, 32'd1);

        // Abort on dut3: PSEL drops during a wait cycle.
        @(posedge clk); #1;
        paddr = 32'h04; pwrite = 1'b1; pwdata = 32'hBAD0_0000; psel3 = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        check("abort_wait", {31'd0, pready3}, 32'd0);
        @(posedge clk); #1;
        psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_state", 32'(dut3.state), 32'd0);
        check("abort_pready", {31'd0, pready3}, 32'd0);
        rd("abort_rd", 1'b1, 32'h04, 32'hDEAD_BEEF, 1'b0);

        // Reset during the ready access cycle of a dut0 ID read.
        @(posedge clk); #1;
        paddr = 32'h00; pwrite = 1'b0; psel0 = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        check("mid_pready", {31'd0, pready0}, 32'd1);
        check("mid_prdata", prdata0, ID);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_pready", {31'd0, pready0}, 32'd0);
        check("mid_rst_prdata", prdata0, 32'd0);
        check("mid_rst_pslverr", {31'd0, pslverr0}, 32'd0);
        check("mid_rst_irq", {31'd0, irq0}, 32'd0);
        psel0 = 1'b0; penable = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        rd("post_scratch", 1'b0, 32'h04, 32'd0, 1'b0);
        rd("post_ctrl", 1'b0, 32'h08, 32'd0, 1'b0);
        rd("post_load", 1'b0, 32'h0C, 32'd0, 1'b0);
        rd("post_count", 1'b0, 32'h10, 32'd0, 1'b0);
        rd("post_status", 1'b0, 32'h14, 32'd0, 1'b0);
        rd("post_scratch3", 1'b1, 32'h04, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
